branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of all PC/target buses.
REQ-002 Parameter IDX_WIDTH, default 4, SHALL set the predictor table index width (2^IDX_WIDTH entries).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 br_valid  input  1  conditional-branch instruction present in EX this cycle.
REQ-006 funct3  input  3  branch funct3 of the EX instruction.
REQ-007 BrEq  input  1  equality result from the branch comparator.
REQ-008 BrLT  input  1  less-than result from the branch comparator.
REQ-009 pred_taken  input  1  prediction carried with the EX instruction from fetch.
REQ-010 br_pc  input  DATA_WIDTH  PC of the EX branch.
REQ-011 br_target  input  DATA_WIDTH  computed taken-target of the EX branch.
REQ-012 fetch_pc  input  DATA_WIDTH  PC being fetched, for prediction lookup.
REQ-013 BrUn  output  1  comparator mode select, combinational from funct3.
REQ-014 pred_out  output  1  combinational prediction for fetch_pc.
REQ-015 PCSel  output  1  registered redirect request to the PC mux.
REQ-016 redirect_pc  output  DATA_WIDTH  registered corrected next PC.
REQ-017 flush  output  1  registered one-cycle squash of younger instructions.
REQ-018 illegal_br  output  1  registered one-cycle pulse for reserved funct3.
REQ-019 mispredict_cnt  output  16  saturating mispredict count.

Function
REQ-020 The comparator in this datapath compares signed when BrUn=1; BrUn SHALL be 1 for funct3 000/001/100/101 and 0 for 110/111; 0 for 010/011.
REQ-021 Actual outcome SHALL be: 000 BrEq; 001 !BrEq; 100 BrLT; 101 !BrLT; 110 BrLT; 111 !BrLT; 010/011 not-taken, reserved.
REQ-022 Table entry = 2-bit saturating counter (0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T); prediction = counter MSB.
REQ-023 pred_out SHALL read entry fetch_pc[IDX_WIDTH+1:2], zero latency, pre-update value on same-cycle write to the same index.
REQ-024 Accepted branch (br_valid=1, legal funct3, FSM in RUN) SHALL update entry br_pc[IDX_WIDTH+1:2] at the edge: taken -> +1 saturating at 3; not-taken -> -1 saturating at 0.
REQ-025 Mispredict = accepted branch with outcome != pred_taken.
REQ-026 Mispredict SHALL, one cycle later, drive flush=1, PCSel=1, redirect_pc = br_target if taken else br_pc+4 (mod 2^DATA_WIDTH), and increment mispredict_cnt, saturating at 0xFFFF.
REQ-027 Correct prediction SHALL drive flush=0, PCSel=0 next cycle; redirect_pc holds its previous value.
REQ-028 FSM states RUN and SQUASH: RUN -> SQUASH on mispredict; SQUASH -> RUN unconditionally next cycle; flush=PCSel=1 exactly while in SQUASH.
REQ-029 In SQUASH, br_valid SHALL be ignored: no table update, no mispredict, no count, no illegal_br.
REQ-030 Reserved funct3 with br_valid in RUN SHALL pulse illegal_br one cycle later, no table update, no redirect, no count.
REQ-031 br_valid=0 SHALL cause no state change other than FSM SQUASH->RUN.

Reset
REQ-032 On rst at a rising edge: all table entries -> 1 (weak-NT), FSM -> RUN, flush/PCSel/illegal_br -> 0, redirect_pc -> 0, mispredict_cnt -> 0.
REQ-033 rst SHALL take priority over every same-cycle event; a pending redirect/flush SHALL be cancelled.
REQ-034 Combinational outputs during reset SHALL reflect reset table contents from the cycle after reset onward.

Structure
REQ-035 A shared package SHALL hold funct3 branch constants, counter encodings (SNT/WNT/WT/ST), and FSM state encoding.
REQ-036 One sub-module, bht_counter2, SHALL implement the 2-bit saturating update (inc/dec inputs, next-state output); the table instantiates or applies it per write.

Verification
REQ-037 After reset, fetch_pc=0x100 -> pred_out=0; BEQ br_pc=0x100, BrEq=1, pred_taken=0, target=0x200 -> next cycle flush=1, PCSel=1, redirect_pc=0x200, mispredict_cnt=1.
REQ-038 BLTU funct3=110 -> BrUn=0; BLT funct3=100 -> BrUn=1; BGE with BrLT=1, pred_taken=0 -> no flush, PCSel=0.
REQ-039 Four taken branches at br_pc=0x40 -> entry saturates at 3; one not-taken, pred_taken=1, br_pc=0x40 -> redirect_pc=0x44, entry=2, pred_out(0x40)=1.
REQ-040 Mispredict, then br_valid=1 mispredicting branch during SQUASH -> flush high one cycle only, count increments once, table unchanged by second branch.
REQ-041 funct3=010, br_valid=1 -> illegal_br pulse next cycle, no flush, count unchanged.
REQ-042 Mispredict edge followed by rst at the next edge -> flush/PCSel=0, count=0, FSM RUN; preload count 0xFFFF then mispredict -> stays 0xFFFF.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants for the branch resolve unit: funct3 codes, 2-bit counter
// encodings, FSM states and funct3 decode helpers.
package branch_resolve_unit_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_RSV2 = 3'b010;
   localparam logic [2:0] F3_RSV3 = 3'b011;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [1:0] CTR_SNT = 2'd0;
   localparam logic [1:0] CTR_WNT = 2'd1;
   localparam logic [1:0] CTR_WT  = 2'd2;
   localparam logic [1:0] CTR_ST  = 2'd3;

   typedef enum logic [0:0] {StRun, StSquash} br_state_e;

   function automatic logic f3_legal(input logic [2:0] f3);
      return !(f3 == F3_RSV2 || f3 == F3_RSV3);
   endfunction

   // The comparator here compares signed when BrUn is high.
   function automatic logic f3_brun(input logic [2:0] f3);
      return (f3 == F3_BEQ || f3 == F3_BNE || f3 == F3_BLT || f3 == F3_BGE);
   endfunction

   function automatic logic f3_taken(input logic [2:0] f3, input logic eq, input logic lt);
      logic t;
      t = 1'b0;
      unique case (f3)
         F3_BEQ:           t = eq;
         F3_BNE:           t = !eq;
         F3_BLT, F3_BLTU:  t = lt;
         F3_BGE, F3_BGEU:  t = !lt;
         default:          t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/bht_counter2.sv
// 2-bit saturating branch history counter: next value from current value
// and an increment or decrement request.
module bht_counter2
   import branch_resolve_unit_pkg::*;
(
   input  logic [1:0] cur_ctr_i,
   input  logic       inc_i,
   input  logic       dec_i,
   output logic [1:0] nxt_ctr_o
);

   always_comb begin
      nxt_ctr_o = cur_ctr_i;
      if (inc_i && cur_ctr_i != CTR_ST) begin
         nxt_ctr_o = cur_ctr_i + 2'd1;
      end else if (dec_i && cur_ctr_i != CTR_SNT) begin
         nxt_ctr_o = cur_ctr_i - 2'd1;
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves EX-stage conditional branches, trains a 2-bit bimodal predictor
// and issues a registered redirect/flush on mispredict.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned IDX_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  br_valid,
   input  logic [2:0]            funct3,
   input  logic                  BrEq,
   input  logic                  BrLT,
   input  logic                  pred_taken,
   input  logic [DATA_WIDTH-1:0] br_pc,
   input  logic [DATA_WIDTH-1:0] br_target,
   input  logic [DATA_WIDTH-1:0] fetch_pc,
   output logic                  BrUn,
   output logic                  pred_out,
   output logic                  PCSel,
   output logic [DATA_WIDTH-1:0] redirect_pc,
   output logic                  flush,
   output logic                  illegal_br,
   output logic [15:0]           mispredict_cnt
);

   localparam int unsigned NumEntries = 2 ** IDX_WIDTH;

   br_state_e             state_q, state_d;
   logic [1:0]            bht_q [NumEntries];
   logic [DATA_WIDTH-1:0] redirect_q, redirect_d;
   logic                  illegal_q, illegal_d;
   logic [15:0]           cnt_q, cnt_d;

   logic                  legal, taken, accept, mispredict;
   logic [IDX_WIDTH-1:0]  wr_idx, rd_idx;
   logic [1:0]            ctr_nxt;
   logic                  unused_fetch_bits;

   assign legal      = f3_legal(funct3);
   assign taken      = f3_taken(funct3, BrEq, BrLT);
   assign accept     = br_valid && legal && (state_q == StRun);
   assign mispredict = accept && (taken != pred_taken);
   assign wr_idx     = br_pc[IDX_WIDTH+1:2];
   assign rd_idx     = fetch_pc[IDX_WIDTH+1:2];

   assign BrUn     = f3_brun(funct3);
   // Read of the registered table gives the pre-update value on a same-cycle write.
   assign pred_out = bht_q[rd_idx][1];

   assign unused_fetch_bits = ^{fetch_pc[DATA_WIDTH-1:IDX_WIDTH+2], fetch_pc[1:0]};

   bht_counter2 u_ctr (
      .cur_ctr_i (bht_q[wr_idx]),
      .inc_i     (taken),
      .dec_i     (!taken),
      .nxt_ctr_o (ctr_nxt)
   );

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun:    state_d = mispredict ? StSquash : StRun;
         StSquash: state_d = StRun;
         default:  state_d = StRun;
      endcase
   end

   // FSM: outputs
   always_comb begin
      flush = 1'b0;
      PCSel = 1'b0;
      if (state_q == StSquash) begin
         flush = 1'b1;
         PCSel = 1'b1;
      end
   end

   always_comb begin
      redirect_d = redirect_q;
      cnt_d      = cnt_q;
      illegal_d  = br_valid && !legal && (state_q == StRun);
      if (mispredict) begin
         redirect_d = taken ? br_target : br_pc + DATA_WIDTH'(4);
         if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_q <= '0;
         illegal_q  <= 1'b0;
         cnt_q      <= '0;
      end else begin
         redirect_q <= redirect_d;
         illegal_q  <= illegal_d;
         cnt_q      <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NumEntries; i++) begin
            bht_q[i] <= CTR_WNT;
         end
      end else if (accept) begin
         bht_q[wr_idx] <= ctr_nxt;
      end
   end

   assign redirect_pc    = redirect_q;
   assign illegal_br     = illegal_q;
   assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        br_valid;
   logic [2:0]  funct3;
   logic        BrEq, BrLT, pred_taken;
   logic [31:0] br_pc, br_target, fetch_pc;
   logic        BrUn, pred_out, PCSel, flush, illegal_br;
   logic [31:0] redirect_pc;
   logic [15:0] mispredict_cnt;

   int checks = 0;
   int failures = 0;

   branch_resolve_unit #(.DATA_WIDTH(32), .IDX_WIDTH(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .br_valid       (br_valid),
      .funct3         (funct3),
      .BrEq           (BrEq),
      .BrLT           (BrLT),
      .pred_taken     (pred_taken),
      .br_pc          (br_pc),
      .br_target      (br_target),
      .fetch_pc       (fetch_pc),
      .BrUn           (BrUn),
      .pred_out       (pred_out),
      .PCSel          (PCSel),
      .redirect_pc    (redirect_pc),
      .flush          (flush),
      .illegal_br     (illegal_br),
      .mispredict_cnt (mispredict_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one branch for a single cycle, then drop br_valid.
   task automatic branch(input logic [2:0] f3, input logic eq, input logic lt,
                         input logic pt, input logic [31:0] pc, input logic [31:0] tgt);
      br_valid = 1'b1; funct3 = f3; BrEq = eq; BrLT = lt; pred_taken = pt;
      br_pc = pc; br_target = tgt;
      tick();
      br_valid = 1'b0;
   endtask

   task automatic peek_pred(input string tag, input logic [31:0] pc, input logic exp);
      fetch_pc = pc;
      #1;
      check(tag, {31'd0, pred_out}, {31'd0, exp});
   endtask

   initial begin
      rst = 1'b1; br_valid = 1'b0; funct3 = 3'b000; BrEq = 1'b0; BrLT = 1'b0;
      pred_taken = 1'b0; br_pc = '0; br_target = '0; fetch_pc = '0;
      tick(); tick();
      rst = 1'b0;
      check("rst_flush", {31'd0, flush}, 32'd0);
      check("rst_pcsel", {31'd0, PCSel}, 32'd0);
      check("rst_illegal", {31'd0, illegal_br}, 32'd0);
      check("rst_redirect", redirect_pc, 32'd0);
      check("rst_cnt", {16'd0, mispredict_cnt}, 32'd0);
      peek_pred("rst_pred_100", 32'h100, 1'b0);

      // BEQ taken, predicted not-taken; entry 0 goes 1 -> 2
      funct3 = 3'b000; #1;
      check("brun_beq", {31'd0, BrUn}, 32'd1);
      branch(3'b000, 1'b1, 1'b0, 1'b0, 32'h100, 32'h200);
      check("beq_flush", {31'd0, flush}, 32'd1);
      check("beq_pcsel", {31'd0, PCSel}, 32'd1);
      check("beq_redirect", redirect_pc, 32'h200);
      check("beq_cnt", {16'd0, mispredict_cnt}, 32'd1);
      peek_pred("beq_pred_100", 32'h100, 1'b1);
      tick();
      check("beq_flush_clr", {31'd0, flush}, 32'd0);

      funct3 = 3'b110; #1; check("brun_bltu", {31'd0, BrUn}, 32'd0);
      funct3 = 3'b100; #1; check("brun_blt", {31'd0, BrUn}, 32'd1);
      funct3 = 3'b010; #1; check("brun_rsv", {31'd0, BrUn}, 32'd0);
      funct3 = 3'b111; #1; check("brun_bgeu", {31'd0, BrUn}, 32'd0);

      // BGE with BrLT=1 is not taken and correctly predicted
      branch(3'b101, 1'b0, 1'b1, 1'b0, 32'h84, 32'h999);
      check("bge_flush", {31'd0, flush}, 32'd0);
      check("bge_pcsel", {31'd0, PCSel}, 32'd0);
      check("bge_redirect_hold", redirect_pc, 32'h200);
      // BLTU taken, predicted not-taken
      branch(3'b110, 1'b0, 1'b1, 1'b0, 32'h88, 32'h300);
      check("bltu_flush", {31'd0, flush}, 32'd1);
      check("bltu_redirect", redirect_pc, 32'h300);
      check("bltu_cnt", {16'd0, mispredict_cnt}, 32'd2);
      tick();
      // BNE taken, predicted taken
      branch(3'b001, 1'b0, 1'b0, 1'b1, 32'h8C, 32'h400);
      check("bne_flush", {31'd0, flush}, 32'd0);
      check("bne_cnt", {16'd0, mispredict_cnt}, 32'd2);
      peek_pred("bge_pred_84", 32'h84, 1'b0);
      peek_pred("bltu_pred_88", 32'h88, 1'b1);

      // Entry 0 (currently 2) saturates at 3 after four taken
      for (int i = 0; i < 4; i++) begin
         branch(3'b000, 1'b1, 1'b0, 1'b1, 32'h40, 32'h80);
         check("sat_no_flush", {31'd0, flush}, 32'd0);
      end
      branch(3'b000, 1'b0, 1'b0, 1'b1, 32'h40, 32'h80);
      check("nt_redirect", redirect_pc, 32'h44);
      check("nt_cnt", {16'd0, mispredict_cnt}, 32'd3);
      peek_pred("nt_pred_40", 32'h40, 1'b1);
      tick();
      branch(3'b000, 1'b0, 1'b0, 1'b1, 32'h40, 32'h80);
      check("nt2_cnt", {16'd0, mispredict_cnt}, 32'd4);
      peek_pred("nt2_pred_40", 32'h40, 1'b0);
      tick();

      // Mispredict then a would-be mispredict during SQUASH is ignored
      branch(3'b000, 1'b1, 1'b0, 1'b0, 32'h14, 32'h500);
      check("sq_flush", {31'd0, flush}, 32'd1);
      br_valid = 1'b1; funct3 = 3'b000; BrEq = 1'b0; pred_taken = 1'b1;
      br_pc = 32'h14; br_target = 32'h600;
      tick();
      br_valid = 1'b0;
      check("sq_flush_once", {31'd0, flush}, 32'd0);
      check("sq_cnt", {16'd0, mispredict_cnt}, 32'd5);
      check("sq_redirect", redirect_pc, 32'h500);
      peek_pred("sq_pred_14", 32'h14, 1'b1);

      // Reserved funct3 pulses illegal_br only
      branch(3'b010, 1'b1, 1'b1, 1'b1, 32'h18, 32'h700);
      check("ill_pulse", {31'd0, illegal_br}, 32'd1);
      check("ill_flush", {31'd0, flush}, 32'd0);
      check("ill_cnt", {16'd0, mispredict_cnt}, 32'd5);
      check("ill_redirect", redirect_pc, 32'h500);
      tick();
      check("ill_pulse_clr", {31'd0, illegal_br}, 32'd0);

      // Reset the cycle after a mispredict edge cancels the squash
      branch(3'b000, 1'b1, 1'b0, 1'b0, 32'h1C, 32'h800);
      check("pre_rst_flush", {31'd0, flush}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst2_flush", {31'd0, flush}, 32'd0);
      check("rst2_pcsel", {31'd0, PCSel}, 32'd0);
      check("rst2_cnt", {16'd0, mispredict_cnt}, 32'd0);
      check("rst2_redirect", redirect_pc, 32'd0);
      peek_pred("rst2_pred_8c", 32'h8C, 1'b0);
      // Reset wins over a same-cycle mispredict
      rst = 1'b1;
      branch(3'b000, 1'b1, 1'b0, 1'b0, 32'h20, 32'h900);
      rst = 1'b0;
      check("rst3_flush", {31'd0, flush}, 32'd0);
      check("rst3_cnt", {16'd0, mispredict_cnt}, 32'd0);
      peek_pred("rst3_pred_20", 32'h20, 1'b0);

      // Counter saturation from a preloaded value
      @(negedge clk);
      force dut.cnt_q = 16'hFFFE;
      #1;
      release dut.cnt_q;
      #1;
      check("preload_cnt", {16'd0, mispredict_cnt}, 32'h0000FFFE);
      branch(3'b000, 1'b1, 1'b0, 1'b0, 32'h24, 32'hA00);
      check("cnt_to_max", {16'd0, mispredict_cnt}, 32'h0000FFFF);
      tick();
      branch(3'b000, 1'b1, 1'b0, 1'b0, 32'h24, 32'hA00);
      check("cnt_sat", {16'd0, mispredict_cnt}, 32'h0000FFFF);
      check("cnt_sat_flush", {31'd0, flush}, 32'd1);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
